// File: rtl/and_out_monitor.sv
// Counts rising edges of an asynchronous AND-gate output over a fixed window of
// WIN_LEN clock cycles. The window is started by a request and the result is held until acknowledged.
module and_out_monitor #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Y,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic [1:0]       state_o
);

  if (WIN_LEN < 1) begin : g_bad_win_len
    $error("and_out_monitor: WIN_LEN must be >= 1");
  end

  localparam int                 WIN_W    = $clog2(WIN_LEN + 1);
  localparam logic [WIN_W-1:0]   WIN_INIT = WIN_W'(WIN_LEN);
  localparam logic [WIN_W-1:0]   WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  // state_o exposes this encoding: IDLE=0, ARM=1, COUNT=2, DONE=3.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s2_q, p_q;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               rise;

  // s1/s2 resolve metastability on Y; p holds the previous synchronised level.
  assign rise = s2_q & ~p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      p_q     <= 1'b0;
      state_q <= S_IDLE;
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= Y;
      s2_q    <= s1_q;
      p_q     <= s2_q;
      state_q <= state_d;
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        count_d = '0;
        ovf_d   = 1'b0;
        win_d   = WIN_INIT;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        win_d = win_q - WIN_ONE;
        // Saturate rather than wrap so a full-scale count is never mistaken for a small one.
        if (rise) begin
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + CNT_ONE;
        end
        if (win_q == WIN_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_ARM) || (state_q == S_COUNT);
  assign done    = (state_q == S_DONE);
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_and_out_monitor.sv
// Bench for and_out_monitor: a wide-counter and a 2-bit-counter instance share stimulus;
// edge counts come from a sampled-Y history model.
module tb_and_out_monitor;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst, Y, start, ack;
  logic       busy_a, done_a, ovf_a;
  logic [7:0] count_a;
  logic [1:0] st_a;
  logic       busy_b, done_b, ovf_b;
  logic [1:0] count_b;
  logic [1:0] st_b;

  int total = 0;
  int bad   = 0;

  bit y_hist[$];
  int y_mode  = 0;
  bit y_level = 1'b0;
  int y_phase = 0;

  typedef struct {
    string nm;
    int    mode;
    bit    level;
    bit    mid;
    int    hold;
    int    c8;
    bit    o8;
    int    c2;
    bit    o2;
  } vec_t;

  vec_t tbl[4];

  and_out_monitor #(.WIN_LEN(WIN), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .Y(Y), .start(start), .ack(ack),
    .busy(busy_a), .done(done_a), .count(count_a), .ovf(ovf_a), .state_o(st_a)
  );

  and_out_monitor #(.WIN_LEN(WIN), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .Y(Y), .start(start), .ack(ack),
    .busy(busy_b), .done(done_b), .count(count_b), .ovf(ovf_b), .state_o(st_b)
  );

  always #5 clk = ~clk;

  // Y as the synchroniser sees it at each rising edge; reset holds the flops at zero.
  always @(posedge clk) y_hist.push_back(rst ? 1'b0 : Y);

  initial begin
    Y = 1'b0;
    forever begin
      @(negedge clk);
      case (y_mode)
        0:       Y = y_level;
        1:       Y = ((y_phase % 4) < 2);
        2:       Y = ((y_phase % 2) == 1);
        default: Y = ($urandom_range(0, 1) == 1);
      endcase
      y_phase++;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Rises of Y first sampled high at edges t..t+WIN-1 land inside the counting window.
  function automatic void model(input int t, input int w, output int c, output bit o);
    int r  = 0;
    int mx = (1 << w) - 1;
    for (int n = t; n < t + WIN; n++) begin
      bit prev = (n > 0) ? y_hist[n-1] : 1'b0;
      if (y_hist[n] && !prev) r++;
    end
    c = (r > mx) ? mx : r;
    o = (r > mx);
  endfunction

  // Called at a negedge; start is sampled on the following rising edge t.
  task automatic run_window(input string nm, input bit mid, input int hold, input bit sa,
                            output int ea, output bit oa, output int eb, output bit ob);
    int t;
    start = 1'b1;
    t = y_hist.size();
    @(negedge clk);
    start = 1'b0;
    chk({nm, " arm busy"}, busy_a, 1);
    for (int k = 1; k <= WIN; k++) begin
      start = (mid && k == 5);
      ack   = (mid && k == 5);
      @(negedge clk);
    end
    start = 1'b0;
    ack   = 1'b0;
    chk({nm, " done early"}, done_a, 0);
    chk({nm, " busy t+17"}, busy_a, 1);
    @(negedge clk);
    chk({nm, " done a"}, done_a, 1);
    chk({nm, " done b"}, done_b, 1);
    chk({nm, " busy off"}, busy_a, 0);
    model(t, 8, ea, oa);
    model(t, 2, eb, ob);
    chk({nm, " count a"}, count_a, ea);
    chk({nm, " ovf a"}, ovf_a, oa);
    chk({nm, " count b"}, count_b, eb);
    chk({nm, " ovf b"}, ovf_b, ob);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold done"}, done_a, 1);
      chk({nm, " hold count"}, count_a, ea);
    end
    ack   = 1'b1;
    start = sa;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    chk({nm, " idle done"}, done_a, 0);
    chk({nm, " idle busy"}, busy_a, 0);
    chk({nm, " idle count"}, count_a, ea);
    chk({nm, " idle ovf b"}, ovf_b, ob);
  endtask

  initial begin
    int  ea, eb;
    bit  oa, ob;
    bit  hit;

    tbl[0] = '{"low",    0, 1'b0, 1'b0, 0,  0, 1'b0, 0, 1'b0};
    tbl[1] = '{"high",   0, 1'b1, 1'b0, 0,  0, 1'b0, 0, 1'b0};
    tbl[2] = '{"square", 1, 1'b0, 1'b1, 10, 4, 1'b0, 3, 1'b1};
    tbl[3] = '{"toggle", 2, 1'b0, 1'b0, 0,  8, 1'b0, 3, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst count", count_a, 0);
    chk("rst ovf", ovf_a, 0);
    chk("rst state", st_a, 0);
    rst = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("idle ack busy", busy_a, 0);
    chk("idle ack done", done_a, 0);

    for (int i = 0; i < 4; i++) begin
      y_mode  = tbl[i].mode;
      y_level = tbl[i].level;
      repeat (6) @(negedge clk);
      run_window(tbl[i].nm, tbl[i].mid, tbl[i].hold, 1'b0, ea, oa, eb, ob);
      chk({tbl[i].nm, " tbl c8"}, ea, tbl[i].c8);
      chk({tbl[i].nm, " tbl o8"}, {31'd0, oa}, {31'd0, tbl[i].o8});
      chk({tbl[i].nm, " tbl c2"}, eb, tbl[i].c2);
      chk({tbl[i].nm, " tbl o2"}, {31'd0, ob}, {31'd0, tbl[i].o2});
    end

    y_mode  = 0;
    y_level = 1'b0;
    repeat (4) @(negedge clk);
    fork
      run_window("one rise", 1'b0, 0, 1'b0, ea, oa, eb, ob);
      begin
        repeat (8) @(negedge clk);
        y_level = 1'b1;
      end
    join
    chk("one rise model", ea, 1);

    y_mode = 3;
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      run_window("random", ($urandom_range(0, 1) == 1), $urandom_range(0, 3), 1'b0, ea, oa, eb, ob);
    end

    y_mode = 2;
    repeat (4) @(negedge clk);
    run_window("start ack", 1'b0, 0, 1'b1, ea, oa, eb, ob);
    @(negedge clk);
    chk("sa stay idle", busy_a, 0);
    chk("sa ovf kept", ovf_b, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sa rearm busy", busy_a, 1);
    chk("sa arm ovf b", ovf_b, 1);
    @(negedge clk);
    chk("sa clr count", count_a, 0);
    chk("sa clr ovf b", ovf_b, 0);
    chk("sa clr count b", count_b, 0);
    repeat (WIN) @(negedge clk);
    chk("sa rewindow done", done_a, 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (count_a == 8'd5) hit = 1'b1;
    end
    chk("reach count 5", {31'd0, hit}, 1);
    #2 rst = 1'b1;
    #1;
    chk("async busy", busy_a, 0);
    chk("async done", done_a, 0);
    chk("async count", count_a, 0);
    chk("async ovf", ovf_a, 0);
    chk("async state", st_a, 0);
    chk("async count b", count_b, 0);
    @(negedge clk);
    rst = 1'b0;
    run_window("post rst", 1'b0, 0, 1'b0, ea, oa, eb, ob);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
